// File: rtl/freq_sweep_analyzer_if.sv
// -----------------------------------------------------------------------------
// freq_sweep_analyzer_if
//   Result channel of the frequency sweep analyzer. One record per sweep point,
//   transferred with a valid/ready handshake.
//   Signals:
//     res_valid   result record available (driven by analyzer)
//     res_ready   consumer accepts the record (driven by readout logic)
//     res_period  sine_gen period the record was measured at
//     res_pp      per-channel unsigned peak-to-peak, WORD_WIDTH+1 bits each
//     res_seen    per-channel flag: at least one valid sample in the window
//   Modports: master = analyzer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface freq_sweep_analyzer_if #(
  parameter int WORD_WIDTH   = 16,
  parameter int NUM_CH       = 10,
  parameter int PERIOD_WIDTH = 32
);
  logic                               res_valid;
  logic                               res_ready;
  logic [PERIOD_WIDTH-1:0]            res_period;
  logic [NUM_CH*(WORD_WIDTH+1)-1:0]   res_pp;
  logic [NUM_CH-1:0]                  res_seen;

  modport master (
    output res_valid, res_period, res_pp, res_seen,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_period, res_pp, res_seen,
    output res_ready
  );
endinterface

// File: rtl/freq_sweep_analyzer.sv
// -----------------------------------------------------------------------------
// freq_sweep_analyzer
//   Steps the sine_gen period from period_start to period_stop. At each point
//   the generator/filters are released, allowed to settle, then every channel's
//   min/max is tracked over a measurement window and a peak-to-peak record is
//   offered on the result interface. Between points the generator is held in
//   reset for GEN_RST_CYCLES cycles.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start, abort    begin a sweep (IDLE only) / cancel at any time
//     period_start/step/stop, settle_cycles, meas_cycles
//                     sweep configuration, latched on start
//     ch_data, ch_valid  filter outputs, channel k at [k*WORD_WIDTH +: WORD_WIDTH]
//     sine_period, gen_run  control of sine_gen and the filter bank
//     busy, done      status: not idle / one-cycle completion pulse
//     res             result channel (master side)
// -----------------------------------------------------------------------------
module freq_sweep_analyzer #(
  parameter int WORD_WIDTH     = 16,
  parameter int NUM_CH         = 10,
  parameter int PERIOD_WIDTH   = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int GEN_RST_CYCLES = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PERIOD_WIDTH-1:0]      period_start,
  input  logic [PERIOD_WIDTH-1:0]      period_step,
  input  logic [PERIOD_WIDTH-1:0]      period_stop,
  input  logic [CNT_WIDTH-1:0]         settle_cycles,
  input  logic [CNT_WIDTH-1:0]         meas_cycles,
  input  logic [NUM_CH*WORD_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [PERIOD_WIDTH-1:0]      sine_period,
  output logic                         gen_run,
  output logic                         busy,
  output logic                         done,
  freq_sweep_analyzer_if.master        res
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEAS, S_REPORT, S_STEP, S_GEN_RST, S_FINISH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] GEN_RST_LAST = CNT_WIDTH'(GEN_RST_CYCLES - 1);
  localparam logic signed [WORD_WIDTH-1:0] POS_MAX = {1'b0, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [WORD_WIDTH-1:0] NEG_MAX = -POS_MAX;

  state_t                  state_reg;
  logic [PERIOD_WIDTH-1:0] period_reg, step_reg, stop_reg, res_period_reg;
  logic [CNT_WIDTH-1:0]    settle_reg, meas_reg, cnt_reg;
  logic                    gen_run_reg, busy_reg, done_reg, res_valid_reg;

  // A zero-length window still lasts one cycle, so the last index saturates at 0.
  logic [CNT_WIDTH-1:0]    settle_last_idx, meas_last_idx;
  logic                    settle_last, meas_last;
  logic [PERIOD_WIDTH:0]   next_period;
  logic                    sweep_end;
  logic                    meas_init, meas_active, meas_capture;

  assign settle_last_idx = (settle_reg == '0) ? '0 : settle_reg - CNT_ONE;
  assign meas_last_idx   = (meas_reg == '0) ? '0 : meas_reg - CNT_ONE;
  assign settle_last     = (cnt_reg == settle_last_idx);
  assign meas_last       = (cnt_reg == meas_last_idx);

  // Extra bit catches wrap-around of the period so the sweep ends instead of restarting low.
  assign next_period = {1'b0, period_reg} + {1'b0, step_reg};
  assign sweep_end   = (step_reg == '0) || next_period[PERIOD_WIDTH] ||
                       (next_period[PERIOD_WIDTH-1:0] > stop_reg);

  assign meas_init    = (state_reg == S_SETTLE) && settle_last;
  assign meas_active  = (state_reg == S_MEAS);
  assign meas_capture = meas_active && meas_last;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_reg      <= S_IDLE;
      period_reg     <= '0;
      step_reg       <= '0;
      stop_reg       <= '0;
      settle_reg     <= '0;
      meas_reg       <= '0;
      cnt_reg        <= '0;
      gen_run_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_period_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            period_reg  <= period_start;
            step_reg    <= period_step;
            stop_reg    <= period_stop;
            settle_reg  <= settle_cycles;
            meas_reg    <= meas_cycles;
            cnt_reg     <= '0;
            gen_run_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_last) begin
            cnt_reg   <= '0;
            state_reg <= S_MEAS;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_MEAS: begin
          if (meas_last) begin
            cnt_reg        <= '0;
            res_valid_reg  <= 1'b1;
            res_period_reg <= period_reg;
            state_reg      <= S_REPORT;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_REPORT: begin
          if (res.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= S_STEP;
          end
        end
        S_STEP: begin
          if (sweep_end) begin
            done_reg  <= 1'b1;
            state_reg <= S_FINISH;
          end else begin
            period_reg  <= next_period[PERIOD_WIDTH-1:0];
            gen_run_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= S_GEN_RST;
          end
        end
        S_GEN_RST: begin
          if (cnt_reg == GEN_RST_LAST) begin
            gen_run_reg <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= S_SETTLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_FINISH: begin
          gen_run_reg <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign sine_period    = period_reg;
  assign gen_run        = gen_run_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign res.res_valid  = res_valid_reg;
  assign res.res_period = res_period_reg;

  // Per-channel min/max tracking. The result is formed from the "next" values so the
  // sample arriving in the final window cycle is included in the reported record.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [WORD_WIDTH-1:0] sample, min_reg, max_reg, min_next, max_next;
      logic                         seen_reg, seen_next, res_seen_reg;
      logic [WORD_WIDTH:0]          pp_reg, pp_next;

      assign sample = ch_data[gi*WORD_WIDTH +: WORD_WIDTH];

      // The first valid sample loads both extremes, so a constant most-negative input
      // reads as zero swing rather than being compared against the -max_signed seed.
      assign min_next  = (ch_valid[gi] && (!seen_reg || sample < min_reg)) ? sample : min_reg;
      assign max_next  = (ch_valid[gi] && (!seen_reg || sample > max_reg)) ? sample : max_reg;
      assign seen_next = seen_reg | ch_valid[gi];
      assign pp_next   = seen_next ? ({max_next[WORD_WIDTH-1], max_next} -
                                      {min_next[WORD_WIDTH-1], min_next}) : '0;

      always_ff @(posedge clk) begin
        if (rst || abort) begin
          min_reg      <= POS_MAX;
          max_reg      <= NEG_MAX;
          seen_reg     <= 1'b0;
          pp_reg       <= '0;
          res_seen_reg <= 1'b0;
        end else begin
          if (meas_init) begin
            min_reg  <= POS_MAX;
            max_reg  <= NEG_MAX;
            seen_reg <= 1'b0;
          end else if (meas_active) begin
            min_reg  <= min_next;
            max_reg  <= max_next;
            seen_reg <= seen_next;
          end
          if (meas_capture) begin
            pp_reg       <= pp_next;
            res_seen_reg <= seen_next;
          end
        end
      end

      assign res.res_pp[gi*(WORD_WIDTH+1) +: WORD_WIDTH+1] = pp_reg;
      assign res.res_seen[gi]                             = res_seen_reg;
    end
  endgenerate

endmodule

// File: tb/tb_freq_sweep_analyzer.sv
module tb_freq_sweep_analyzer;

  localparam int W  = 16;
  localparam int NC = 10;
  localparam int PW = 32;
  localparam int CW = 32;
  localparam int PPW = NC * (W + 1);
  // ch0, ch1, ch2, ch4, ch5 are driven valid every cycle; ch3 and ch6..9 never valid.
  localparam logic [NC-1:0] SEEN_EXP = 10'b00_0011_0111;

  typedef struct {
    logic [PW-1:0] p_start;
    logic [PW-1:0] p_step;
    logic [PW-1:0] p_stop;
    logic [CW-1:0] settle;
    logic [CW-1:0] meas;
    int            n_exp;
  } cfg_t;

  typedef struct {
    logic [PW-1:0]  period;
    logic [PPW-1:0] pp;
    logic [NC-1:0]  seen;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [PW-1:0] period_start, period_step, period_stop, sine_period;
  logic [CW-1:0] settle_cycles, meas_cycles;
  logic [NC*W-1:0] ch_data;
  logic [NC-1:0] ch_valid;
  logic gen_run, busy, done;

  freq_sweep_analyzer_if #(.WORD_WIDTH(W), .NUM_CH(NC), .PERIOD_WIDTH(PW)) res_if ();

  freq_sweep_analyzer #(
    .WORD_WIDTH(W), .NUM_CH(NC), .PERIOD_WIDTH(PW), .CNT_WIDTH(CW), .GEN_RST_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period_start(period_start), .period_step(period_step), .period_stop(period_stop),
    .settle_cycles(settle_cycles), .meas_cycles(meas_cycles),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .sine_period(sine_period), .gen_run(gen_run), .busy(busy), .done(done),
    .res(res_if.master)
  );

  always #2 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int res_cnt = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb_q[$];
  cfg_t cfgs[5];

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [PPW-1:0] exp_pp(input logic [CW-1:0] meas);
    logic [PPW-1:0] v;
    v = '0;
    if (meas >= 4) begin
      v[0*17 +: 17] = 17'd2000;
      v[2*17 +: 17] = 17'd65535;
      v[5*17 +: 17] = 17'd700;
    end
    return v;
  endfunction

  // Expected record list for one sweep, derived from the configuration alone.
  task automatic push_sweep(input cfg_t c);
    logic [PW-1:0] p;
    logic [PW:0]   nx;
    exp_t e;
    p = c.p_start;
    while (1) begin
      e.period = p;
      e.pp     = exp_pp(c.meas);
      e.seen   = SEEN_EXP;
      sb_q.push_back(e);
      nx = {1'b0, p} + {1'b0, c.p_step};
      if (c.p_step == '0 || nx[PW] || nx[PW-1:0] > c.p_stop) break;
      p = nx[PW-1:0];
    end
  endtask

  task automatic start_sweep(input cfg_t c);
    period_start  = c.p_start;
    period_step   = c.p_step;
    period_stop   = c.p_stop;
    settle_cycles = c.settle;
    meas_cycles   = c.meas;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 200'(busy), 200'(1));
    chk("gen_run_after_start", 200'(gen_run), 200'(1));
    chk("period_after_start", 200'(sine_period), 200'(c.p_start));
  endtask

  task automatic wait_done(input int n_exp, input int res0, input int done0);
    int guard;
    guard = 0;
    while (done_cnt == done0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 200'(done_cnt - done0), 200'(1));
    chk("result_count", 200'(res_cnt - res0), 200'(n_exp));
    chk("sb_drained", 200'(sb_q.size()), 200'(0));
    chk("idle_after_done", 200'({busy, gen_run, res_if.res_valid}), 200'(0));
  endtask

  task automatic wait_res_valid(input string name);
    int guard;
    guard = 0;
    while (!res_if.res_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk(name, 200'(res_if.res_valid), 200'(1));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_outputs"}, 200'({sine_period, gen_run, busy, done, res_if.res_valid}), 200'(0));
    chk({name, "_res"}, 200'({res_if.res_period, res_if.res_pp, res_if.res_seen}), 200'(0));
  endtask

  // Channel stimulus: patterns whose swing is the same over any window of >=4 cycles.
  logic [31:0] ph = '0;
  always @(negedge clk) begin
    logic [NC*W-1:0] d;
    ph = ph + 1;
    d = '0;
    d[0*W +: W] = ph[0] ? 16'sd1000 : -16'sd1000;
    d[1*W +: W] = 16'sd7;
    d[2*W +: W] = ph[0] ? 16'h7FFF : 16'h8000;
    d[3*W +: W] = 16'h1234;
    d[4*W +: W] = -16'sd5;
    case (ph[1:0])
      2'd0:    d[5*W +: W] = -16'sd300;
      2'd1:    d[5*W +: W] = 16'sd100;
      2'd2:    d[5*W +: W] = 16'sd400;
      default: d[5*W +: W] = -16'sd50;
    endcase
    d[6*W +: 4*W] = {$urandom, $urandom};
    ch_data  = d;
    ch_valid = SEEN_EXP;
  end

  // Result monitor / scoreboard, done-pulse and generator-reset-gap checks.
  always @(negedge clk) begin
    exp_t e;
    if (res_if.res_valid && res_if.res_ready) begin
      chk("result_expected", 200'(sb_q.size() != 0), 200'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("[TB] result period=%0d seen=%b pp0=%0d pp2=%0d", res_if.res_period,
                 res_if.res_seen, res_if.res_pp[0 +: 17], res_if.res_pp[34 +: 17]);
        chk("res_period", 200'(res_if.res_period), 200'(e.period));
        chk("res_pp", 200'(res_if.res_pp), 200'(e.pp));
        chk("res_seen", 200'(res_if.res_seen), 200'(e.seen));
      end
      res_cnt++;
    end
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", 200'(prev_done), 200'(0));
    end
    prev_done = done;
    if (!busy) begin
      low_cnt = 0;
    end else if (!gen_run) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      chk("gen_rst_length", 200'(low_cnt), 200'(100));
      low_cnt = 0;
    end
  end

  initial begin
    int r0, d0;
    logic stable;
    logic [PW-1:0]  snap_period;
    logic [PPW-1:0] snap_pp;
    logic [NC-1:0]  snap_seen;

    cfgs[0] = '{32'd50, 32'd50, 32'd200, 32'd20, 32'd100, 4};
    cfgs[1] = '{32'd300, 32'd50, 32'd200, 32'd5, 32'd8, 1};
    cfgs[2] = '{32'd10, 32'd0, 32'd1000, 32'd3, 32'd6, 1};
    cfgs[3] = '{32'd100, 32'd7, 32'd120, 32'd0, 32'd0, 3};
    cfgs[4] = '{32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF, 32'd2, 32'd5, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    period_start = '0; period_step = '0; period_stop = '0;
    settle_cycles = '0; meas_cycles = '0;
    res_if.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Table-driven sweeps.
    for (int i = 0; i < 5; i++) begin
      r0 = res_cnt; d0 = done_cnt;
      push_sweep(cfgs[i]);
      start_sweep(cfgs[i]);
      wait_done(cfgs[i].n_exp, r0, d0);
    end

    // Back-pressure at the first point; config changes and start while busy are ignored.
    res_if.res_ready = 1'b0;
    r0 = res_cnt; d0 = done_cnt;
    push_sweep(cfgs[0]);
    start_sweep(cfgs[0]);
    wait_res_valid("stall_res_valid");
    snap_period = res_if.res_period;
    snap_pp     = res_if.res_pp;
    snap_seen   = res_if.res_seen;
    period_start = 32'd999; period_step = 32'd1; period_stop = 32'd5000;
    stable = 1'b1;
    for (int k = 0; k < 500; k++) begin
      start = (k == 10);
      @(negedge clk);
      if (!res_if.res_valid || !gen_run || !busy || res_if.res_period !== snap_period ||
          res_if.res_pp !== snap_pp || res_if.res_seen !== snap_seen)
        stable = 1'b0;
    end
    start = 1'b0;
    chk("stall_hold", 200'(stable), 200'(1));
    res_if.res_ready = 1'b1;
    wait_done(4, r0, d0);

    // Abort in the measurement window.
    r0 = res_cnt; d0 = done_cnt;
    start_sweep(cfgs[0]);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_all_zero("abort");
    repeat (300) @(negedge clk);
    chk("abort_no_done", 200'(done_cnt - d0), 200'(0));
    chk("abort_no_result", 200'(res_cnt - r0), 200'(0));

    // Start and abort together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 200'({busy, gen_run}), 200'(0));

    // Reset while a result is pending.
    res_if.res_ready = 1'b0;
    r0 = res_cnt; d0 = done_cnt;
    start_sweep(cfgs[1]);
    wait_res_valid("rst_res_valid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst_report");
    res_if.res_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", 200'(done_cnt - d0), 200'(0));
    chk("rst_no_result", 200'(res_cnt - r0), 200'(0));

    // Clean sweep after abort/reset.
    r0 = res_cnt; d0 = done_cnt;
    push_sweep(cfgs[3]);
    start_sweep(cfgs[3]);
    wait_done(cfgs[3].n_exp, r0, d0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
